// File: rtl/rec_play_ctrl.sv
// rec_play_ctrl - record/playback sequencer for a 2^ADDR_W x DATA_W async SRAM.
//
// Record mode writes each ADC sample to the next sequential address; play
// mode reads samples back in order, one per DAC request. Every access runs
// SETUP (1 clk) -> STROBE (STROBE_CYC clks) -> HOLD (1 clk). All SRAM
// controls are registered, so the pins are glitch-free and the asynchronous
// reset forces them inactive immediately.
//
// Request handshake: adc_valid / dac_req are single-cycle pulses with no
// ready back-pressure. A pulse seen while idle starts an access on the next
// clock. A pulse seen in the HOLD clock is queued as the one pending request.
// Any other pulse seen while busy is dropped and sets the sticky overrun flag.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   record_btn, play_btn, stop_btn   one-cycle control pulses
//   adc_valid, adc_data  sample to record
//   dac_req              request for the next playback sample
//   sram_rdata           data read back from the SRAM io bus
//   sram_addr, sram_wdata, sram_wr_en (1 = drive the io bus)
//   sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  active-low strobes
//   dac_data, dac_valid  last sample read, pulsed in the HOLD clock
//   mode                 00 IDLE, 01 REC, 10 PLAY (top FSM state)
//   end_addr             number of recorded samples
//   overrun              sticky: a sample or request was dropped
//
// Build option: define REC_PLAY_LOOP_EN to make playback wrap to address 0
// at end_addr and keep playing until stop_btn. When it is undefined,
// playback returns to IDLE at end_addr.

module rec_play_ctrl #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              record_btn,
  input  logic              play_btn,
  input  logic              stop_btn,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              dac_req,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_wr_en,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic [1:0]        mode,
  output logic [ADDR_W:0]   end_addr,
  output logic              overrun
);

  localparam int CNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  PTR_LAST = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_REC  = 2'b01,
    MODE_PLAY = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ACC_READY  = 2'b00,
    ACC_SETUP  = 2'b01,
    ACC_STROBE = 2'b10,
    ACC_HOLD   = 2'b11
  } acc_e;

  // Top FSM and access sub-FSM
  mode_e             mode_q, mode_d;
  acc_e              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // The pointer is one bit wider than the address so that it can hold the
  // sample count 2^ADDR_W when the memory is full.
  logic [ADDR_W:0]   pointer_q, pointer_d;
  logic              pending_q, pending_d;
  logic              stopping_q, stopping_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [ADDR_W:0]   end_addr_q, end_addr_d;
  logic              overrun_q, overrun_d;

  // Registered SRAM / DAC outputs
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic              ce_n_q, ce_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] dac_data_q, dac_data_d;
  logic              dac_valid_q, dac_valid_d;

  // Combinational helpers
  logic              req;
  logic              new_req;
  logic              done;
  logic              leave;
  logic              wr_acc;
  logic              rd_acc;
  logic              busy_d;
  logic [ADDR_W:0]   pointer_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_IDLE;
      acc_q        <= ACC_READY;
      cnt_q        <= '0;
      pointer_q    <= '0;
      pending_q    <= 1'b0;
      stopping_q   <= 1'b0;
      sample_q     <= '0;
      end_addr_q   <= '0;
      overrun_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      ce_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      wr_en_q      <= 1'b0;
      dac_data_q   <= '0;
      dac_valid_q  <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      pointer_q    <= pointer_d;
      pending_q    <= pending_d;
      stopping_q   <= stopping_d;
      sample_q     <= sample_d;
      end_addr_q   <= end_addr_d;
      overrun_q    <= overrun_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      ce_n_q       <= ce_n_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      wr_en_q      <= wr_en_d;
      dac_data_q   <= dac_data_d;
      dac_valid_q  <= dac_valid_d;
    end
  end

  always_comb begin
    mode_d       = mode_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    pointer_d    = pointer_q;
    pending_d    = pending_q;
    stopping_d   = stopping_q;
    sample_d     = sample_q;
    end_addr_d   = end_addr_q;
    overrun_d    = overrun_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    dac_data_d   = dac_data_q;
    ce_n_d       = 1'b1;
    we_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    wr_en_d      = 1'b0;
    dac_valid_d  = 1'b0;
    done         = 1'b0;
    leave        = 1'b0;
    req          = 1'b0;
    busy_d       = 1'b0;
    pointer_inc  = pointer_q + PTR_ONE;
    wr_acc       = (mode_q == MODE_REC);
    rd_acc       = (mode_q == MODE_PLAY);

    if (wr_acc) begin
      req = adc_valid;
    end else if (rd_acc) begin
      req = dac_req;
    end
    // Once stop is seen no further request is taken; a sample that arrives
    // together with stop_btn is simply not recorded.
    new_req = req && !stop_btn && !stopping_q;

    // ---------------- access sub-FSM ----------------
    case (acc_q)
      ACC_READY: begin
        if (pending_q) begin
          acc_d     = ACC_SETUP;
          pending_d = 1'b0;
          if (new_req) begin
            overrun_d = 1'b1;
          end
        end else if (new_req) begin
          acc_d    = ACC_SETUP;
          sample_d = adc_data;
        end
      end
      ACC_SETUP: begin
        acc_d = ACC_STROBE;
        cnt_d = '0;
        if (new_req) begin
          overrun_d = 1'b1;
        end
      end
      ACC_STROBE: begin
        if (cnt_q == CNT_LAST) begin
          acc_d = ACC_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (new_req) begin
          overrun_d = 1'b1;
        end
      end
      ACC_HOLD: begin
        acc_d = ACC_READY;
        done  = 1'b1;
        // A request in the last clock of an access is queued, not dropped.
        if (new_req) begin
          pending_d = 1'b1;
          sample_d  = adc_data;
        end
      end
      default: acc_d = ACC_READY;
    endcase

    // ---------------- top FSM ----------------
    case (mode_q)
      MODE_IDLE: begin
        if (record_btn) begin
          mode_d     = MODE_REC;
          pointer_d  = '0;
          overrun_d  = 1'b0;
          pending_d  = 1'b0;
          stopping_d = 1'b0;
        end else if (play_btn && (end_addr_q != '0)) begin
          mode_d     = MODE_PLAY;
          pointer_d  = '0;
          pending_d  = 1'b0;
          stopping_d = 1'b0;
        end
      end
      MODE_REC: begin
        if (done) begin
          pointer_d = pointer_inc;
          // Stop requested earlier, stop now, or the last address was written.
          if (stopping_q || stop_btn || (pointer_q == PTR_LAST)) begin
            end_addr_d = pointer_inc;
            leave      = 1'b1;
          end
        end else if (stop_btn) begin
          if (acc_q == ACC_READY) begin
            end_addr_d = pointer_q;
            leave      = 1'b1;
          end else begin
            stopping_d = 1'b1;
          end
        end
      end
      MODE_PLAY: begin
        if (done) begin
          pointer_d = pointer_inc;
          if (stopping_q || stop_btn) begin
            leave = 1'b1;
          end else if (pointer_inc == end_addr_q) begin
`ifdef REC_PLAY_LOOP_EN
            pointer_d = '0;
`else
            leave = 1'b1;
`endif
          end
        end else if (stop_btn) begin
          if (acc_q == ACC_READY) begin
            leave = 1'b1;
          end else begin
            stopping_d = 1'b1;
          end
        end
      end
      default: mode_d = MODE_IDLE;
    endcase

    if (leave) begin
      mode_d     = MODE_IDLE;
      acc_d      = ACC_READY;
      pending_d  = 1'b0;
      stopping_d = 1'b0;
      // A request queued in HOLD is lost when the session ends there.
      if (done && new_req) begin
        overrun_d = 1'b1;
      end
    end

    // ---------------- registered SRAM controls ----------------
    // Decoded from the next access state so each pin changes on the same
    // edge as the state it belongs to.
    busy_d = (acc_d != ACC_READY);
    if (acc_q == ACC_READY && acc_d == ACC_SETUP) begin
      sram_addr_d = pointer_q[ADDR_W-1:0];
      if (wr_acc) begin
        sram_wdata_d = pending_q ? sample_q : adc_data;
      end
    end
    ce_n_d      = !busy_d;
    wr_en_d     = busy_d && wr_acc;
    we_n_d      = !((acc_d == ACC_STROBE) && wr_acc);
    oe_n_d      = !(((acc_d == ACC_SETUP) || (acc_d == ACC_STROBE)) && rd_acc);
    dac_valid_d = (acc_d == ACC_HOLD) && rd_acc;
    // Read data is taken at the end of the last STROBE clock, while oe_n is
    // still low.
    if (acc_q == ACC_STROBE && acc_d == ACC_HOLD && rd_acc) begin
      dac_data_d = sram_rdata;
    end
  end

  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_wr_en = wr_en_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_ub_n  = ce_n_q;
  assign sram_lb_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign dac_data   = dac_data_q;
  assign dac_valid  = dac_valid_q;
  assign mode       = mode_q;
  assign end_addr   = end_addr_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_rec_play_ctrl.sv
module tb_rec_play_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic record_btn, play_btn, stop_btn, adc_valid, dac_req;
  logic [15:0] adc_data;

  // Default-size instance
  logic [15:0] sram_rdata, sram_wdata, dac_data;
  logic [17:0] sram_addr;
  logic        sram_wr_en, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic        dac_valid, overrun;
  logic [1:0]  mode;
  logic [18:0] end_addr;

  // ADDR_W=4 instance, fed the same inputs
  logic [15:0] sram_rdata4, sram_wdata4, dac_data4;
  logic [3:0]  sram_addr4;
  logic        sram_wr_en4, sram_ce_n4, sram_oe_n4, sram_we_n4, sram_ub_n4, sram_lb_n4;
  logic        dac_valid4, overrun4;
  logic [1:0]  mode4;
  logic [4:0]  end_addr4;

  rec_play_ctrl dut (
    .clk(clk), .rst_n(rst_n), .record_btn(record_btn), .play_btn(play_btn),
    .stop_btn(stop_btn), .adc_valid(adc_valid), .adc_data(adc_data), .dac_req(dac_req),
    .sram_rdata(sram_rdata), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_wr_en(sram_wr_en), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
    .dac_data(dac_data), .dac_valid(dac_valid), .mode(mode), .end_addr(end_addr),
    .overrun(overrun)
  );

  rec_play_ctrl #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .record_btn(record_btn), .play_btn(play_btn),
    .stop_btn(stop_btn), .adc_valid(adc_valid), .adc_data(adc_data), .dac_req(dac_req),
    .sram_rdata(sram_rdata4), .sram_addr(sram_addr4), .sram_wdata(sram_wdata4),
    .sram_wr_en(sram_wr_en4), .sram_ce_n(sram_ce_n4), .sram_oe_n(sram_oe_n4),
    .sram_we_n(sram_we_n4), .sram_ub_n(sram_ub_n4), .sram_lb_n(sram_lb_n4),
    .dac_data(dac_data4), .dac_valid(dac_valid4), .mode(mode4), .end_addr(end_addr4),
    .overrun(overrun4)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM models ----------------
  logic [15:0] mem_a [0:31];
  logic [15:0] mem_b [0:15];

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_wr_en) mem_a[sram_addr[4:0]] <= sram_wdata;
    if (!sram_ce_n4 && !sram_we_n4 && sram_wr_en4) mem_b[sram_addr4] <= sram_wdata4;
  end

  assign sram_rdata  = (!sram_ce_n && !sram_oe_n) ? mem_a[sram_addr[4:0]] : 16'h0000;
  assign sram_rdata4 = (!sram_ce_n4 && !sram_oe_n4) ? mem_b[sram_addr4] : 16'h0000;

  // we_n and oe_n low together is recorded and checked once at the end.
  logic overlap_seen = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ((!sram_we_n && !sram_oe_n) || (!sram_we_n4 && !sram_oe_n4)))
      overlap_seen <= 1'b1;
  end

  // ---------------- tables ----------------
  // Pin vector: {ce_n, ub_n, lb_n, we_n, oe_n, wr_en, dac_valid}
  typedef struct packed {
    logic ce_n; logic ub_n; logic lb_n; logic we_n; logic oe_n; logic wr_en; logic dac_valid;
  } wave_t;

  typedef struct packed {
    logic [15:0] data;     // input sample
    logic [17:0] addr;     // expected SRAM address
  } smp_t;

  wave_t wr_wave [5];
  wave_t rd_wave [5];
  smp_t  smp     [3];

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic wave_t pins();
    return '{ce_n: sram_ce_n, ub_n: sram_ub_n, lb_n: sram_lb_n, we_n: sram_we_n,
             oe_n: sram_oe_n, wr_en: sram_wr_en, dac_valid: dac_valid};
  endfunction

  // One write or read access, checking the pins in each of its five clocks
  // (SETUP, STROBE, STROBE, HOLD, back to ready). Starts right after an edge.
  task automatic do_access(input logic is_wr, input logic [15:0] data,
                           input logic [17:0] exp_addr, input logic [15:0] exp_dac,
                           input string tag);
    wave_t w;
    if (is_wr) begin
      adc_valid = 1'b1;
      adc_data  = data;
    end else begin
      dac_req = 1'b1;
    end
    for (int p = 0; p < 5; p++) begin
      tick();
      adc_valid = 1'b0;
      dac_req   = 1'b0;
      @(negedge clk);
      w = is_wr ? wr_wave[p] : rd_wave[p];
      check($sformatf("%s pins p%0d", tag, p), 32'(pins()), 32'(w));
      if (p == 0) check({tag, " addr"}, 32'(sram_addr), 32'(exp_addr));
      if (p == 0 && is_wr) check({tag, " wdata"}, 32'(sram_wdata), 32'(data));
      if (p == 3 && !is_wr) check({tag, " dac_data"}, 32'(dac_data), 32'(exp_dac));
    end
  endtask

  task automatic pulse_btn(input int which);
    case (which)
      0: record_btn = 1'b1;
      1: play_btn   = 1'b1;
      2: stop_btn   = 1'b1;
      default: begin record_btn = 1'b1; play_btn = 1'b1; end
    endcase
    tick();
    record_btn = 1'b0;
    play_btn   = 1'b0;
    stop_btn   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    wr_wave[0] = 7'b000_1_1_1_0;  // SETUP
    wr_wave[1] = 7'b000_0_1_1_0;  // STROBE
    wr_wave[2] = 7'b000_0_1_1_0;  // STROBE
    wr_wave[3] = 7'b000_1_1_1_0;  // HOLD
    wr_wave[4] = 7'b111_1_1_0_0;  // ready
    rd_wave[0] = 7'b000_1_0_0_0;
    rd_wave[1] = 7'b000_1_0_0_0;
    rd_wave[2] = 7'b000_1_0_0_0;
    rd_wave[3] = 7'b000_1_1_0_1;
    rd_wave[4] = 7'b111_1_1_0_0;
    smp[0] = '{data: 16'h1111, addr: 18'd0};
    smp[1] = '{data: 16'h2222, addr: 18'd1};
    smp[2] = '{data: 16'h3333, addr: 18'd2};

    // ---------------- reset ----------------
    rst_n = 1'b0;
    record_btn = 1'b0; play_btn = 1'b0; stop_btn = 1'b0;
    adc_valid = 1'b0; dac_req = 1'b0; adc_data = 16'h0000;
    repeat (3) tick();
    @(negedge clk);
    check("reset pins", 32'(pins()), 32'(7'b111_1_1_0_0));
    check("reset mode", 32'(mode), 32'd0);
    check("reset end_addr", 32'(end_addr), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset addr", 32'(sram_addr), 32'd0);
    check("reset dac_data", 32'(dac_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // play with nothing recorded is ignored
    pulse_btn(1);
    check("play empty mode", 32'(mode), 32'd0);

    // ---------------- record three samples ----------------
    tick();
    pulse_btn(0);
    check("rec mode", 32'(mode), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      do_access(1'b1, smp[i].data, smp[i].addr, 16'h0, $sformatf("wr%0d", i));
      repeat (2) tick();
    end
    tick();
    pulse_btn(2);
    check("rec stop mode", 32'(mode), 32'd0);
    check("rec end_addr", 32'(end_addr), 32'd3);
    check("rec overrun", 32'(overrun), 32'd0);

    // ---------------- play them back ----------------
    tick();
    pulse_btn(1);
    check("play mode", 32'(mode), 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      do_access(1'b0, 16'h0, smp[i].addr, smp[i].data, $sformatf("rd%0d", i));
`ifdef REC_PLAY_LOOP_EN
      check($sformatf("rd%0d mode", i), 32'(mode), 32'd2);
`else
      check($sformatf("rd%0d mode", i), 32'(mode), (i == 2) ? 32'd0 : 32'd2);
`endif
      if (i == 0) begin
        tick();
        pulse_btn(0);
        check("rec in play ignored", 32'(mode), 32'd2);
      end
    end
`ifdef REC_PLAY_LOOP_EN
    tick();
    do_access(1'b0, 16'h0, 18'd0, 16'h1111, "rd_wrap");
    check("wrap mode", 32'(mode), 32'd2);
    tick();
    pulse_btn(2);
    check("loop stop mode", 32'(mode), 32'd0);
`endif
    check("play end_addr kept", 32'(end_addr), 32'd3);

    // ---------------- overrun: second sample during an access ----------------
    tick();
    pulse_btn(0);
    adc_valid = 1'b1; adc_data = 16'hAAAA;
    tick();
    adc_valid = 1'b0;
    tick();
    adc_valid = 1'b1; adc_data = 16'hBBBB;    // arrives in STROBE
    tick();
    adc_valid = 1'b0;
    @(negedge clk);
    check("overrun set", 32'(overrun), 32'd1);
    repeat (4) tick();
    pulse_btn(2);
    check("ovr end_addr", 32'(end_addr), 32'd1);
    check("overrun sticky", 32'(overrun), 32'd1);
    check("ovr mem0", 32'(mem_a[0]), 32'hAAAA);
    check("ovr mem1 untouched", 32'(mem_a[1]), 32'h2222);

    // new record clears overrun; a sample in HOLD is queued, not dropped
    tick();
    pulse_btn(0);
    check("overrun cleared", 32'(overrun), 32'd0);
    adc_valid = 1'b1; adc_data = 16'hCCCC;
    tick();
    adc_valid = 1'b0;
    repeat (3) tick();
    adc_valid = 1'b1; adc_data = 16'hDDDD;    // arrives in HOLD
    tick();
    adc_valid = 1'b0;
    repeat (8) tick();
    pulse_btn(2);
    check("hold end_addr", 32'(end_addr), 32'd2);
    check("hold overrun", 32'(overrun), 32'd0);
    check("hold mem0", 32'(mem_a[0]), 32'hCCCC);
    check("hold mem1", 32'(mem_a[1]), 32'hDDDD);

    // stop together with a sample: the sample is not recorded
    tick();
    pulse_btn(0);
    stop_btn = 1'b1; adc_valid = 1'b1; adc_data = 16'hEEEE;
    tick();
    stop_btn = 1'b0; adc_valid = 1'b0;
    @(negedge clk);
    check("stop+adc mode", 32'(mode), 32'd0);
    check("stop+adc ce_n", 32'(sram_ce_n), 32'd1);
    check("stop+adc end_addr", 32'(end_addr), 32'd0);
    repeat (4) tick();
    check("stop+adc mem0", 32'(mem_a[0]), 32'hCCCC);
    pulse_btn(1);
    check("play empty mode 2", 32'(mode), 32'd0);

    // record and play together from IDLE -> record wins
    tick();
    pulse_btn(3);
    check("rec+play mode", 32'(mode), 32'd1);
    tick();
    do_access(1'b1, 16'h5A5A, 18'd0, 16'h0, "wr_rp");
    tick();
    pulse_btn(2);
    check("rec+play end_addr", 32'(end_addr), 32'd1);

    // ---------------- reset in the middle of a write strobe ----------------
    tick();
    pulse_btn(0);
    adc_valid = 1'b1; adc_data = 16'h7777;
    tick();
    adc_valid = 1'b0;
    tick();
    @(negedge clk);
    check("midwr we_n low", 32'(sram_we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midwr we_n", 32'(sram_we_n), 32'd1);
    check("midwr ce_n", 32'(sram_ce_n), 32'd1);
    check("midwr wr_en", 32'(sram_wr_en), 32'd0);
    check("midwr mode", 32'(mode), 32'd0);
    check("midwr end_addr", 32'(end_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- fill: ADDR_W=4 instance stops itself at 16 ----------------
    pulse_btn(0);
    for (int i = 0; i < 16; i++) begin
      tick();
      adc_valid = 1'b1; adc_data = 16'h0100 + 16'(i);
      tick();
      adc_valid = 1'b0;
      repeat (4) tick();
    end
    @(negedge clk);
    check("full mode4", 32'(mode4), 32'd0);
    check("full end_addr4", 32'(end_addr4), 32'd16);
    check("full mem_b0", 32'(mem_b[0]), 32'h0100);
    check("full mem_b15", 32'(mem_b[15]), 32'h010F);
    check("big still rec", 32'(mode), 32'd1);
    tick();
    pulse_btn(2);
    check("big end_addr", 32'(end_addr), 32'd16);

    check("we_n/oe_n never both low", 32'(overlap_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
